// File: rtl/matmul_pkg.sv
// Shared defaults, FSM state type and address arithmetic helper for the C-side address generator.
package matmul_pkg;

  localparam int unsigned ADDR_W_DEF  = 6;
  localparam int unsigned STRIDE_DEF  = 8;
  localparam int unsigned MAX_DIM_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addr_gen_state_t;

  // Modulo-2**width add; callers truncate the result to their own address width.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [31:0] inc,
                                            input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (addr + inc) & mask;
  endfunction

endpackage

// File: rtl/matmul_idx_counter.sv
// Nested row/col index counter: captures tile limits, advances col first, then row,
// and keeps a registered flag marking the final position of the tile.
module matmul_idx_counter
  import matmul_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_rows,
  input  logic [CNT_W-1:0] i_cols,
  input  logic             i_adv,
  output logic [CNT_W-1:0] o_row,
  output logic [CNT_W-1:0] o_col,
  output logic             o_col_wrap,
  output logic             o_last
);

  logic [CNT_W-1:0] r_rows_m1;
  logic [CNT_W-1:0] r_cols_m1;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic             r_last;

  logic             w_col_wrap;
  logic [CNT_W-1:0] w_nrow;
  logic [CNT_W-1:0] w_ncol;

  // Next index position: wrap col to 0 and bump row at the end of each row.
  always_comb begin
    w_col_wrap = (r_col == r_cols_m1);
    w_nrow     = r_row;
    w_ncol     = r_col + CNT_W'(1);
    if (w_col_wrap) begin
      w_nrow = r_row + CNT_W'(1);
      w_ncol = '0;
    end
  end

  // Limit capture, index advance and last-position flag, all registered together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rows_m1 <= '0;
      r_cols_m1 <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_last    <= 1'b0;
    end else if (i_load) begin
      r_rows_m1 <= i_rows - CNT_W'(1);
      r_cols_m1 <= i_cols - CNT_W'(1);
      r_row     <= '0;
      r_col     <= '0;
      r_last    <= (i_rows == CNT_W'(1)) && (i_cols == CNT_W'(1));
    end else if (i_adv) begin
      r_row     <= w_nrow;
      r_col     <= w_ncol;
      r_last    <= (w_nrow == r_rows_m1) && (w_ncol == r_cols_m1);
    end
  end

  assign o_row      = r_row;
  assign o_col      = r_col;
  assign o_col_wrap = w_col_wrap;
  assign o_last     = r_last;

endmodule

// File: rtl/matmul_addr_gen.sv
// Row-major tile walker for the C memory: emits base + row*STRIDE + col one beat per
// handshake, built incrementally from a row-base accumulator instead of a multiplier.
module matmul_addr_gen
  import matmul_pkg::*;
#(
  parameter  int unsigned ADDR_W  = ADDR_W_DEF,
  parameter  int unsigned STRIDE  = STRIDE_DEF,
  parameter  int unsigned MAX_DIM = MAX_DIM_DEF,
  localparam int unsigned CNT_W   = $clog2(MAX_DIM + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [CNT_W-1:0]  rows_i,
  input  logic [CNT_W-1:0]  cols_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [CNT_W-1:0]  row_o,
  output logic [CNT_W-1:0]  col_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);

  addr_gen_state_t r_state;
  addr_gen_state_t w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_row_base;
  logic              r_valid;

  logic [CNT_W-1:0]  w_rows_c;
  logic [CNT_W-1:0]  w_cols_c;
  logic              w_nonzero;
  logic              w_launch;
  logic              w_fire;
  logic              w_last;
  logic              w_col_wrap;
  logic              w_adv;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_row_next;
  logic              w_busy;
  logic              w_done;

  // Input clamping, handshake decode and incremental address candidates.
  always_comb begin
    w_rows_c   = (rows_i > CNT_W'(MAX_DIM)) ? CNT_W'(MAX_DIM) : rows_i;
    w_cols_c   = (cols_i > CNT_W'(MAX_DIM)) ? CNT_W'(MAX_DIM) : cols_i;
    w_nonzero  = (w_rows_c != '0) && (w_cols_c != '0);
    w_launch   = (r_state == IDLE) && start_i && w_nonzero;
    w_fire     = r_valid && ready_i;
    w_adv      = w_fire && !w_last;
    w_addr_inc = ADDR_W'(next_addr(32'(r_addr), 32'd1, ADDR_W));
    w_row_next = ADDR_W'(next_addr(32'(r_row_base), 32'(STRIDE), ADDR_W));
  end

  matmul_idx_counter #(
    .CNT_W (CNT_W)
  ) u_idx (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_launch),
    .i_rows     (w_rows_c),
    .i_cols     (w_cols_c),
    .i_adv      (w_adv),
    .o_row      (row_o),
    .o_col      (col_o),
    .o_col_wrap (w_col_wrap),
    .o_last     (w_last)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic; zero-sized tiles go straight to DONE without a beat.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (start_i) w_state_nxt = w_nonzero ? RUN : DONE;
      RUN:  if (w_fire && w_last) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM output decode from the registered state.
  always_comb begin
    w_busy = (r_state == RUN) || (r_state == DONE);
    w_done = (r_state == DONE);
  end

  // Beat datapath: load base on launch, step col or jump to the next row base on handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_addr     <= '0;
      r_row_base <= '0;
    end else if (w_launch) begin
      r_valid    <= 1'b1;
      r_addr     <= base_i;
      r_row_base <= base_i;
    end else if (w_fire) begin
      if (w_last) begin
        r_valid    <= 1'b0;
      end else if (w_col_wrap) begin
        r_row_base <= w_row_next;
        r_addr     <= w_row_next;
      end else begin
        r_addr     <= w_addr_inc;
      end
    end
  end

  assign addr_o  = r_addr;
  assign valid_o = r_valid;
  assign last_o  = w_last;
  assign busy_o  = w_busy;
  assign done_o  = w_done;

endmodule

// File: tb/tb_matmul_addr_gen.sv
// Directed bench for matmul_addr_gen: table of tile walks with hand-computed results,
// a per-beat reference from the closed-form address, and hand sequences for reset.
module tb_matmul_addr_gen;

  localparam int AW = 6;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [AW-1:0] base_i = '0;
  logic [CW-1:0] rows_i = '0;
  logic [CW-1:0] cols_i = '0;
  logic [AW-1:0] addr_o;
  logic [CW-1:0] row_o;
  logic [CW-1:0] col_o;
  logic          valid_o;
  logic          last_o;
  logic          busy_o;
  logic          done_o;

  matmul_addr_gen #(
    .ADDR_W  (6),
    .STRIDE  (8),
    .MAX_DIM (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .base_i  (base_i),
    .rows_i  (rows_i),
    .cols_i  (cols_i),
    .addr_o  (addr_o),
    .row_o   (row_o),
    .col_o   (col_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .last_o  (last_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] addr;
    logic [3:0] row;
    logic [3:0] col;
    logic       last;
  } beat_t;

  typedef struct {
    logic [5:0] base;
    logic [3:0] rows;
    logic [3:0] cols;
    int         stall;
    int         inject;
    int         exp_beats;
    int         exp_done;
    logic [5:0] exp_last_addr;
  } walk_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t got[$];
  walk_t walks[9];
  beat_t exp1[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_walk(input walk_t w, output int done_cyc);
    int    busy_cnt;
    logic  prev_stall;
    beat_t prev;
    got.delete();
    done_cyc   = -1;
    busy_cnt   = 0;
    prev_stall = 1'b0;
    prev       = '{default: '0};
    base_i  = w.base;
    rows_i  = w.rows;
    cols_i  = w.cols;
    start_i = 1'b1;
    ready_i = 1'b1;
    step();
    for (int cyc = 0; cyc < 300; cyc++) begin
      ready_i = (w.stall != 0) ? (cyc % 3 == 0) : 1'b1;
      if (w.inject != 0 && cyc == 1) begin
        start_i = 1'b1;
        base_i  = 6'd40;
        rows_i  = 4'd1;
        cols_i  = 4'd1;
      end else begin
        start_i = 1'b0;
      end
      if (prev_stall) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_addr", addr_o, prev.addr);
        chk("hold_row", row_o, prev.row);
        chk("hold_col", col_o, prev.col);
        chk("hold_last", last_o, prev.last);
      end
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cyc = cyc;
        chk("valid_at_done", valid_o, 0);
        break;
      end
      if (valid_o && ready_i) got.push_back('{addr_o, row_o, col_o, last_o});
      prev_stall = valid_o && !ready_i;
      prev       = '{addr_o, row_o, col_o, last_o};
      step();
    end
    start_i = 1'b0;
    ready_i = 1'b0;
    if (done_cyc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL walk_timeout: got no done_o within 300 cycles, required done_o");
    end else begin
      chk("busy_cycles", busy_cnt, done_cyc + 1);
    end
    step();
    chk("done_one_cycle", done_o, 0);
    chk("busy_after_done", busy_o, 0);
  endtask

  task automatic check_walk(input walk_t w, input int idx);
    int dc;
    int er;
    int ec;
    int k;
    run_walk(w, dc);
    chk($sformatf("w%0d_done_cyc", idx), dc, w.exp_done);
    chk($sformatf("w%0d_beats", idx), got.size(), w.exp_beats);
    if (w.exp_beats > 0 && got.size() > 0)
      chk($sformatf("w%0d_last_addr", idx), got[got.size()-1].addr, w.exp_last_addr);
    er = (w.rows > 8) ? 8 : int'(w.rows);
    ec = (w.cols > 8) ? 8 : int'(w.cols);
    k  = 0;
    for (int r = 0; r < er; r++) begin
      for (int c = 0; c < ec; c++) begin
        if (k < got.size()) begin
          chk($sformatf("w%0d_b%0d_addr", idx, k), got[k].addr, (int'(w.base) + r*8 + c) % 64);
          chk($sformatf("w%0d_b%0d_row", idx, k), got[k].row, r);
          chk($sformatf("w%0d_b%0d_col", idx, k), got[k].col, c);
          chk($sformatf("w%0d_b%0d_last", idx, k), got[k].last, (r == er-1) && (c == ec-1));
        end
        k++;
      end
    end
  endtask

  initial begin
    int dc;

    // base, rows, cols, stall, inject, beats, done cycle, last addr
    walks[0] = '{6'd0,  4'd2,  4'd3,  0, 0, 6, 6,  6'd10};
    walks[1] = '{6'd0,  4'd2,  4'd3,  1, 0, 6, 16, 6'd10};
    walks[2] = '{6'd60, 4'd1,  4'd6,  0, 0, 6, 6,  6'd1};
    walks[3] = '{6'd0,  4'd0,  4'd5,  0, 0, 0, 0,  6'd0};
    walks[4] = '{6'd5,  4'd2,  4'd2,  0, 1, 4, 4,  6'd14};
    walks[5] = '{6'd62, 4'd15, 4'd1,  0, 0, 8, 8,  6'd54};
    walks[6] = '{6'd3,  4'd1,  4'd1,  0, 0, 1, 1,  6'd3};
    walks[7] = '{6'd7,  4'd3,  4'd0,  0, 0, 0, 0,  6'd0};
    walks[8] = '{6'd0,  4'd1,  4'd12, 1, 0, 8, 22, 6'd7};

    exp1[0] = '{6'd0,  4'd0, 4'd0, 1'b0};
    exp1[1] = '{6'd1,  4'd0, 4'd1, 1'b0};
    exp1[2] = '{6'd2,  4'd0, 4'd2, 1'b0};
    exp1[3] = '{6'd8,  4'd1, 4'd0, 1'b0};
    exp1[4] = '{6'd9,  4'd1, 4'd1, 1'b0};
    exp1[5] = '{6'd10, 4'd1, 4'd2, 1'b1};

    rst_n = 1'b0;
    step();
    step();
    chk("rst_valid", valid_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_row", row_o, 0);
    chk("rst_col", col_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      check_walk(walks[i], i);
      if (i == 0) begin
        for (int b = 0; b < 6; b++) begin
          if (b < got.size()) begin
            chk($sformatf("t1_b%0d_addr", b), got[b].addr, exp1[b].addr);
            chk($sformatf("t1_b%0d_last", b), got[b].last, exp1[b].last);
          end
        end
      end
      step();
    end

    // Reset in the middle of a 4x4 walk once three beats have been accepted.
    base_i  = 6'd20;
    rows_i  = 4'd4;
    cols_i  = 4'd4;
    start_i = 1'b1;
    ready_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    step();
    chk("mid_addr_before_rst", addr_o, 23);
    rst_n = 1'b0;
    step();
    chk("abort_valid", valid_o, 0);
    chk("abort_addr", addr_o, 0);
    chk("abort_row", row_o, 0);
    chk("abort_col", col_o, 0);
    chk("abort_last", last_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    rst_n   = 1'b1;
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_abort_done", done_o, 0);
      chk("post_abort_valid", valid_o, 0);
    end
    check_walk('{6'd9, 4'd2, 4'd2, 0, 0, 4, 4, 6'd18}, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
